// File: rtl/xpu_vpu_pc_tn_vlsu_fp_nan_scan_pkg.sv
// Shared constants for the VLSU NaN/Inf scanner: mode encoding, field widths, canonical quiet NaNs.
// Canonicalisation build option: XPU_VPU_NAN_CANON_EN.
package xpu_vpu_fp_pkg;

  localparam logic [1:0] FP_BF16 = 2'b00;
  localparam logic [1:0] FP_FP16 = 2'b01;
  localparam logic [1:0] FP_FP32 = 2'b10;
  localparam logic [1:0] FP_RAW  = 2'b11;

  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  localparam logic [15:0] QNAN_BF16 = 16'h7FC0;
  localparam logic [15:0] QNAN_FP16 = 16'h7E00;
  localparam logic [31:0] QNAN_FP32 = 32'h7FC0_0000;

endpackage

// File: rtl/xpu_vpu_pc_tn_vlsu_fp_nan_scan_if.sv
// Beat-in / beat-out / vector-summary bundle of the NaN scanner; master = producer+consumer, slave = scanner.
interface xpu_vpu_pc_tn_vlsu_fp_nan_scan_if #(
  parameter int LANES = 4,
  parameter int CNT_W = 8
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*32-1:0]   in_data;
  logic [1:0]            in_mode;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*32-1:0]   out_data;
  logic [2*LANES-1:0]    out_nan_mask;
  logic [2*LANES-1:0]    out_snan_mask;
  logic                  out_last;
  logic                  sum_valid;
  logic [CNT_W-1:0]      sum_nan_cnt;
  logic                  sum_snan_any;
  logic                  sum_inf_any;

  modport master (
    output in_valid, in_data, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_nan_mask, out_snan_mask, out_last,
           sum_valid, sum_nan_cnt, sum_snan_any, sum_inf_any
  );
  modport slave (
    input  in_valid, in_data, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_data, out_nan_mask, out_snan_mask, out_last,
           sum_valid, sum_nan_cnt, sum_snan_any, sum_inf_any
  );
endinterface

// File: rtl/xpu_vpu_pc_tn_vlsu_fp_nan_scan_elem_class.sv
// Combinational classifier for one 32-bit lane: two 16-bit elements or one fp32 element.
// With XPU_VPU_NAN_CANON_EN, NaN elements are replaced by the mode's canonical quiet NaN.
module xpu_vpu_fp_elem_class
  import xpu_vpu_fp_pkg::*;
(
  input  logic [31:0] i_lane,
  input  logic [1:0]  i_mode,
  output logic [1:0]  o_nan,
  output logic [1:0]  o_snan,
  output logic [1:0]  o_inf,
  output logic [31:0] o_lane
);

  always_comb begin
    logic [15:0] w_h;
    logic        w_eo, w_mz, w_q;
    o_nan  = '0;
    o_snan = '0;
    o_inf  = '0;
    o_lane = i_lane;
    w_h    = '0;
    w_eo   = 1'b0;
    w_mz   = 1'b0;
    w_q    = 1'b0;
    case (i_mode)
      FP_BF16, FP_FP16: begin
        for (int k = 0; k < 2; k++) begin
          w_h = i_lane[16*k +: 16];
          if (i_mode == FP_BF16) begin
            w_eo = &w_h[14 -: BF16_EXP_W];
            w_mz = |w_h[BF16_MAN_W-1:0];
            w_q  = w_h[BF16_MAN_W-1];
          end else begin
            w_eo = &w_h[14 -: FP16_EXP_W];
            w_mz = |w_h[FP16_MAN_W-1:0];
            w_q  = w_h[FP16_MAN_W-1];
          end
          o_nan[k]  = w_eo & w_mz;
          o_snan[k] = w_eo & w_mz & ~w_q;
          o_inf[k]  = w_eo & ~w_mz;
`ifdef XPU_VPU_NAN_CANON_EN
          if (w_eo & w_mz) o_lane[16*k +: 16] = (i_mode == FP_BF16) ? QNAN_BF16 : QNAN_FP16;
`endif
        end
      end
      FP_FP32: begin
        w_eo      = &i_lane[30 -: FP32_EXP_W];
        w_mz      = |i_lane[FP32_MAN_W-1:0];
        w_q       = i_lane[FP32_MAN_W-1];
        o_nan[0]  = w_eo & w_mz;
        o_snan[0] = w_eo & w_mz & ~w_q;
        o_inf[0]  = w_eo & ~w_mz;
`ifdef XPU_VPU_NAN_CANON_EN
        if (w_eo & w_mz) o_lane = QNAN_FP32;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/xpu_vpu_pc_tn_vlsu_fp_nan_scan.sv
// Multi-lane NaN/Inf scanner on the VLSU load path: single output register plus per-vector summary.
// Optional NaN canonicalisation of out_data: XPU_VPU_NAN_CANON_EN.
module xpu_vpu_pc_tn_vlsu_fp_nan_scan
  import xpu_vpu_fp_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  input logic clr,
  xpu_vpu_pc_tn_vlsu_fp_nan_scan_if.slave bus
);

  localparam int PC_W  = $clog2(2*LANES+1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((64'd1 << CNT_W) - 64'd1);

  logic [LANES-1:0][1:0]  w_nan, w_snan, w_inf;
  logic [LANES-1:0][31:0] w_lane;
  logic [2*LANES-1:0]     w_nan_mask, w_snan_mask;
  logic [PC_W-1:0]        w_pc;
  logic [SUM_W-1:0]       w_sum;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_push, w_pop, w_snan_next, w_inf_next;

  logic                   r_out_valid, r_out_last, r_sum_valid, r_sum_snan, r_sum_inf;
  logic [LANES*32-1:0]    r_out_data;
  logic [2*LANES-1:0]     r_nan_mask, r_snan_mask;
  logic [CNT_W-1:0]       r_sum_cnt, r_acc_cnt;
  logic                   r_acc_snan, r_acc_inf;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    xpu_vpu_fp_elem_class u_cls (
      .i_lane (bus.in_data[32*g +: 32]),
      .i_mode (bus.in_mode),
      .o_nan  (w_nan[g]),
      .o_snan (w_snan[g]),
      .o_inf  (w_inf[g]),
      .o_lane (w_lane[g])
    );
  end

  assign w_nan_mask  = w_nan;
  assign w_snan_mask = w_snan;

  always_comb begin
    w_pc = '0;
    for (int i = 0; i < 2*LANES; i++) w_pc = w_pc + PC_W'(w_nan_mask[i]);
  end

  // Running totals including the current beat; also the summary value when in_last.
  assign w_sum       = SUM_W'(r_acc_cnt) + SUM_W'(w_pc);
  assign w_cnt_next  = (w_sum > CNT_MAX) ? '1 : w_sum[CNT_W-1:0];
  assign w_snan_next = r_acc_snan | (|w_snan_mask);
  assign w_inf_next  = r_acc_inf | (|w_inf);

  assign bus.in_ready = ~clr & (~r_out_valid | bus.out_ready);
  assign w_push       = bus.in_valid & bus.in_ready;
  assign w_pop        = r_out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_nan_mask  <= '0;
      r_snan_mask <= '0;
      r_sum_valid <= 1'b0;
      r_sum_cnt   <= '0;
      r_sum_snan  <= 1'b0;
      r_sum_inf   <= 1'b0;
      r_acc_cnt   <= '0;
      r_acc_snan  <= 1'b0;
      r_acc_inf   <= 1'b0;
    end else if (clr) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_sum_valid <= 1'b0;
      r_acc_cnt   <= '0;
      r_acc_snan  <= 1'b0;
      r_acc_inf   <= 1'b0;
    end else begin
      r_sum_valid <= 1'b0;
      if (w_push) begin
        r_out_valid <= 1'b1;
        r_out_last  <= bus.in_last;
        r_out_data  <= w_lane;
        r_nan_mask  <= w_nan_mask;
        r_snan_mask <= w_snan_mask;
        if (bus.in_last) begin
          r_sum_valid <= 1'b1;
          r_sum_cnt   <= w_cnt_next;
          r_sum_snan  <= w_snan_next;
          r_sum_inf   <= w_inf_next;
          r_acc_cnt   <= '0;
          r_acc_snan  <= 1'b0;
          r_acc_inf   <= 1'b0;
        end else begin
          r_acc_cnt   <= w_cnt_next;
          r_acc_snan  <= w_snan_next;
          r_acc_inf   <= w_inf_next;
        end
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid     = r_out_valid;
  assign bus.out_last      = r_out_last;
  assign bus.out_data      = r_out_data;
  assign bus.out_nan_mask  = r_nan_mask;
  assign bus.out_snan_mask = r_snan_mask;
  assign bus.sum_valid     = r_sum_valid;
  assign bus.sum_nan_cnt   = r_sum_cnt;
  assign bus.sum_snan_any  = r_sum_snan;
  assign bus.sum_inf_any   = r_sum_inf;

endmodule

// File: tb/tb_xpu_vpu_pc_tn_vlsu_fp_nan_scan.sv
// Self-checking bench for the NaN scanner: directed table, corner sequences, randomized traffic vs model.
module tb_xpu_vpu_pc_tn_vlsu_fp_nan_scan;

  localparam int LANES = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  xpu_vpu_pc_tn_vlsu_fp_nan_scan_if #(.LANES(LANES), .CNT_W(CNT_W)) bus ();

  xpu_vpu_pc_tn_vlsu_fp_nan_scan #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_tot  = 0;

  // reference state
  logic         m_ov, m_last, m_sv, m_ssnan, m_sinf, acc_s, acc_i;
  logic [127:0] m_data;
  logic [7:0]   m_nan, m_snan;
  int           m_scnt, acc_n;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Classify straight from the IEEE-style field rules using shift/mask arithmetic.
  task automatic classify(input logic [1:0] mode, input logic [127:0] d,
                          output logic [7:0] nan, output logic [7:0] snan,
                          output logic inf, output logic [127:0] cd);
    int ew, mw, esz, nel;
    logic [63:0] x, e, m, cv;
    nan = '0; snan = '0; inf = 1'b0; cd = d;
    ew = 8; mw = 7; esz = 16; nel = 2; cv = 64'h7FC0;
    if (mode == 2'd1) begin ew = 5; mw = 10; cv = 64'h7E00; end
    if (mode == 2'd2) begin ew = 8; mw = 23; esz = 32; nel = 1; cv = 64'h7FC0_0000; end
    if (mode != 2'd3) begin
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < nel; k++) begin
          x = 64'(d >> (32*i + esz*k)) & ((64'd1 << esz) - 64'd1);
          e = (x >> mw) & ((64'd1 << ew) - 64'd1);
          m = x & ((64'd1 << mw) - 64'd1);
          if (e == (64'd1 << ew) - 64'd1) begin
            if (m != 0) begin
              nan[2*i+k] = 1'b1;
              if (((m >> (mw-1)) & 64'd1) == 64'd0) snan[2*i+k] = 1'b1;
`ifdef XPU_VPU_NAN_CANON_EN
              for (int b = 0; b < esz; b++) cd[32*i + esz*k + b] = cv[b];
`endif
            end else inf = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic model_reset();
    m_ov = 0; m_last = 0; m_sv = 0; m_ssnan = 0; m_sinf = 0; m_scnt = 0;
    m_data = '0; m_nan = '0; m_snan = '0;
    acc_n = 0; acc_s = 0; acc_i = 0;
  endtask

  task automatic check_out();
    chk("out_valid", 128'(bus.out_valid), 128'(m_ov));
    if (m_ov) begin
      chk("out_data", bus.out_data, m_data);
      chk("out_nan_mask", 128'(bus.out_nan_mask), 128'(m_nan));
      chk("out_snan_mask", 128'(bus.out_snan_mask), 128'(m_snan));
      chk("out_last", 128'(bus.out_last), 128'(m_last));
    end
    chk("sum_valid", 128'(bus.sum_valid), 128'(m_sv));
    chk("sum_nan_cnt", 128'(bus.sum_nan_cnt), 128'(m_scnt));
    chk("sum_snan_any", 128'(bus.sum_snan_any), 128'(m_ssnan));
    chk("sum_inf_any", 128'(bus.sum_inf_any), 128'(m_sinf));
  endtask

  // One clock: inputs already driven; check ready, advance model at the edge, check outputs after.
  task automatic cyc();
    logic rdy, acc, inf;
    logic [7:0] nan, snan;
    logic [127:0] cd;
    #2;
    rdy = !clr && (!m_ov || bus.out_ready);
    chk("in_ready", 128'(bus.in_ready), 128'(rdy));
    acc = bus.in_valid && rdy;
    @(posedge clk);
    if (clr) begin
      m_ov = 0; m_sv = 0; m_last = 0; acc_n = 0; acc_s = 0; acc_i = 0;
    end else begin
      m_sv = 0;
      if (acc) begin
        classify(bus.in_mode, bus.in_data, nan, snan, inf, cd);
        m_ov = 1; m_data = cd; m_nan = nan; m_snan = snan; m_last = bus.in_last;
        acc_n += $countones(nan); acc_s |= (snan != 0); acc_i |= inf;
        if (bus.in_last) begin
          m_sv = 1;
          m_scnt = (acc_n > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : acc_n;
          m_ssnan = acc_s; m_sinf = acc_i;
          acc_n = 0; acc_s = 0; acc_i = 0;
        end
      end else if (m_ov && bus.out_ready) m_ov = 0;
    end
    #1;
    check_out();
  endtask

  task automatic drive(input logic v, input logic [1:0] md, input logic [127:0] d, input logic l);
    bus.in_valid = v; bus.in_mode = md; bus.in_data = d; bus.in_last = l;
  endtask

  function automatic logic [15:0] rh();
    logic [15:0] h;
    case ($urandom % 5)
      0: h = 16'($urandom);
      1: h = 16'h7F80 | 16'($urandom % 128);
      2: h = 16'h7C00 | 16'($urandom % 1024);
      3: h = 16'h7F80;
      default: h = 16'h7C00;
    endcase
    h[15] = 1'($urandom % 2);
    return h;
  endfunction

  typedef struct {
    logic [1:0]   mode;
    logic [127:0] data;
    logic [7:0]   nan;
    logic [7:0]   snan;
    int           cnt;
    logic         inf;
    logic         sany;
  } vec_t;

  vec_t tv[6];
  logic [127:0] beats[5];

  initial begin
    bus.in_valid = 0; bus.in_data = '0; bus.in_mode = '0; bus.in_last = 0; bus.out_ready = 1;
    tv[0] = '{2'd0, {96'h0, 32'h7FC1_7F80}, 8'h02, 8'h00, 1, 1'b1, 1'b0};
    tv[1] = '{2'd1, {96'h0, 32'h7C01_7E00}, 8'h03, 8'h02, 2, 1'b0, 1'b1};
    tv[2] = '{2'd2, {96'h0, 32'h7F80_0001}, 8'h01, 8'h01, 1, 1'b0, 1'b1};
    tv[3] = '{2'd3, {96'h0, 32'h7F80_0001}, 8'h00, 8'h00, 0, 1'b0, 1'b0};
    tv[4] = '{2'd2, {96'h0, 32'hFF80_0000}, 8'h00, 8'h00, 0, 1'b1, 1'b0};
    tv[5] = '{2'd0, {64'h0, 32'hFFFF_0001, 32'h0}, 8'h08, 8'h00, 1, 1'b0, 1'b0};

    // reset state
    #3;
    model_reset();
    chk("rst_out_data", bus.out_data, 128'h0);
    chk("rst_nan_mask", 128'(bus.out_nan_mask), 128'h0);
    check_out();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // directed single-beat vectors
    for (int i = 0; i < 6; i++) begin
      drive(1, tv[i].mode, tv[i].data, 1);
      cyc();
      chk($sformatf("tv%0d_nan", i), 128'(bus.out_nan_mask), 128'(tv[i].nan));
      chk($sformatf("tv%0d_snan", i), 128'(bus.out_snan_mask), 128'(tv[i].snan));
      chk($sformatf("tv%0d_sumv", i), 128'(bus.sum_valid), 128'h1);
      chk($sformatf("tv%0d_cnt", i), 128'(bus.sum_nan_cnt), 128'(tv[i].cnt));
      chk($sformatf("tv%0d_inf", i), 128'(bus.sum_inf_any), 128'(tv[i].inf));
      chk($sformatf("tv%0d_sany", i), 128'(bus.sum_snan_any), 128'(tv[i].sany));
      if (i == 1) begin
`ifdef XPU_VPU_NAN_CANON_EN
        chk("fp16_canon", bus.out_data, {96'h0, 32'h7E00_7E00});
`else
        chk("fp16_copy", bus.out_data, {96'h0, 32'h7C01_7E00});
`endif
      end
      drive(0, 2'd0, '0, 0);
      cyc();
      chk($sformatf("tv%0d_pulse", i), 128'(bus.sum_valid), 128'h0);
    end

    // backpressure: held output, then back-to-back throughput
    for (int i = 0; i < 5; i++) beats[i] = {32'(i), 32'h7F80_0001, 32'(i*7), 32'h1234_0000 + 32'(i)};
    drive(1, 2'd2, beats[0], 0); bus.out_ready = 1; cyc();
    bus.out_ready = 0;
    drive(1, 2'd2, beats[1], 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_ready", 128'(bus.in_ready), 128'h0);
      chk("bp_hold", bus.out_data[31:0], {96'h0, beats[0][31:0]});
    end
    bus.out_ready = 1;
    for (int i = 1; i < 5; i++) begin
      drive(1, 2'd2, beats[i], i == 4);
      cyc();
      chk("b2b_data", bus.out_data[127:64], {64'h0, beats[i][127:64]});
    end
    chk("b2b_cnt", 128'(bus.sum_nan_cnt), 128'd5);
    drive(0, 2'd0, '0, 0); cyc();

    // saturation: 40 beats of 8 bf16 NaNs
    for (int i = 0; i < 40; i++) begin
      drive(1, 2'd0, {4{32'h7FC0_FF81}}, i == 39);
      cyc();
    end
    chk("sat_cnt", 128'(bus.sum_nan_cnt), 128'd255);
    chk("sat_snan", 128'(bus.sum_snan_any), 128'd1);
    drive(0, 2'd0, '0, 0); cyc();

    // clr mid-vector
    drive(1, 2'd0, {4{32'h7FC0_7FC0}}, 0); cyc(); cyc();
    clr = 1; cyc();
    chk("clr_ov", 128'(bus.out_valid), 128'h0);
    clr = 0;
    drive(1, 2'd0, {96'h0, 32'h0000_7FC1}, 1); cyc();
    chk("clr_cnt", 128'(bus.sum_nan_cnt), 128'd1);
    drive(0, 2'd0, '0, 0); cyc();

    // async reset mid-vector
    drive(1, 2'd0, {4{32'h7FC0_7FC0}}, 0); cyc(); cyc();
    drive(0, 2'd0, '0, 0);
    #2 rst_n = 0; #1;
    model_reset();
    chk("rst_mid_ov", 128'(bus.out_valid), 128'h0);
    chk("rst_mid_cnt", 128'(bus.sum_nan_cnt), 128'h0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    drive(1, 2'd1, {96'h0, 32'h7C01_0000}, 1); cyc();
    chk("rst_cnt", 128'(bus.sum_nan_cnt), 128'd1);
    drive(0, 2'd0, '0, 0); cyc();

    // randomized traffic vs model
    for (int n = 0; n < 600; n++) begin
      logic [127:0] d;
      for (int h = 0; h < 8; h++) d[16*h +: 16] = rh();
      drive(1'($urandom % 4 != 0), 2'($urandom % 4), d, 1'($urandom % 5 == 0));
      bus.out_ready = 1'($urandom % 4 != 0);
      clr = 1'($urandom % 40 == 0);
      cyc();
    end
    clr = 0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
